// File: rtl/switch_cfg_loader.sv
// switch_cfg_loader: byte-serial configuration writer for one switch-matrix tile.
// Accepts a framed stream (0xA5 header, N route bytes, XOR checksum), checks every
// route code, builds the image in a shadow register and commits it to cfg_bus in a
// single cycle. Bytes of a rejected frame never reach the tile.
// Ports:
//   clk, rst   clock (rising edge) and asynchronous active-high reset
//   cfg_valid  stream byte valid
//   cfg_ready  loader can take a byte (transfer = cfg_valid & cfg_ready)
//   cfg_data   stream byte
//   cfg_bus    N*CW flat route image, entry k at [k*CW +: CW]
//   cfg_done   1-cycle pulse when cfg_bus is updated
//   cfg_err    1-cycle pulse when a frame is rejected
//   busy       frame in progress (header accepted, no verdict yet)
module switch_cfg_loader #(
  parameter int unsigned NTOP  = 5,
  parameter int unsigned NSIDE = 4,
  parameter int unsigned CW    = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [7:0]                      cfg_data,
  output logic [(2*NTOP+2*NSIDE)*CW-1:0]  cfg_bus,
  output logic                            cfg_done,
  output logic                            cfg_err,
  output logic                            busy
);

  localparam int unsigned N    = 2 * NTOP + 2 * NSIDE;
  localparam int unsigned BW   = N * CW;
  localparam int unsigned CNTW = $clog2(N);

  localparam logic [7:0] HEADER = 8'hA5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CNTW-1:0] count_q;
  logic [7:0]      chk_q;
  logic            bad_q;
  logic [BW-1:0]   shadow_q;
  logic            xfer;

  assign xfer = cfg_valid & cfg_ready;

  // Route code legality: [7:6] zero, side in 0..4, index bounded by the side's wire count.
  function automatic logic code_ok(input logic [7:0] b);
    logic [2:0] side;
    logic [2:0] idx;
    side = b[2:0];
    idx  = b[5:3];
    if (b[7:6] != 2'b00) return 1'b0;
    case (side)
      3'd0:       return 1'b1;
      3'd1, 3'd3: return (32'(idx) < NTOP);
      3'd2, 3'd4: return (32'(idx) < NSIDE);
      default:    return 1'b0;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (xfer && cfg_data == HEADER) state_d = S_LOAD;
      S_LOAD:   if (xfer && count_q == CNTW'(N - 1)) state_d = S_CHECK;
      S_CHECK:  if (xfer) state_d = (!bad_q && cfg_data == chk_q) ? S_COMMIT : S_ERR;
      S_COMMIT: state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Frame accumulation: shadow image, running checksum and sticky bad-code flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      chk_q    <= '0;
      bad_q    <= 1'b0;
      shadow_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (xfer && cfg_data == HEADER) begin
        count_q <= '0;
        chk_q   <= '0;
        bad_q   <= 1'b0;
      end
    end else if (state_q == S_LOAD && xfer) begin
      shadow_q[32'(count_q) * CW +: CW] <= cfg_data[CW-1:0];
      chk_q   <= chk_q ^ cfg_data;
      bad_q   <= bad_q | ~code_ok(cfg_data);
      count_q <= count_q + CNTW'(1);
    end
  end

  // Registered outputs; handshake and busy are decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_bus   <= '0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      cfg_done  <= (state_q == S_COMMIT);
      cfg_err   <= (state_q == S_ERR);
      cfg_ready <= !(state_d == S_COMMIT || state_d == S_ERR);
      busy      <= (state_d == S_LOAD || state_d == S_CHECK);
      if (state_q == S_COMMIT) cfg_bus <= shadow_q;
    end
  end

endmodule

// File: tb/tb_switch_cfg_loader.sv
// tb_switch_cfg_loader: directed bench for switch_cfg_loader with a frame-level
// reference model compared against every DUT output on every cycle.
module tb_switch_cfg_loader;

  localparam int N  = 18;
  localparam int CW = 6;
  localparam int BW = N * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [7:0]    cfg_data;
  logic [BW-1:0] cfg_bus;
  logic          cfg_done;
  logic          cfg_err;
  logic          busy;

  always #5 clk = ~clk;

  switch_cfg_loader dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_bus   (cfg_bus),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Legal route code by the tile's rules (5 top/bottom wires, 4 side wires).
  function automatic bit legal(input logic [7:0] b);
    int side, idx;
    side = int'(b[2:0]);
    idx  = int'(b[5:3]);
    if (b[7:6] != 2'b00) return 0;
    if (side == 0) return 1;
    if (side == 1 || side == 3) return idx < 5;
    if (side == 2 || side == 4) return idx < 4;
    return 0;
  endfunction

  // Reference model: collect accepted bytes, judge a whole frame at once.
  logic [7:0]    fb[$];
  bit            in_frame, pend, pend_ok;
  logic [BW-1:0] pend_img;
  logic [BW-1:0] exp_bus;
  bit            exp_done, exp_err, exp_ready, exp_busy;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        fb.delete();
        in_frame = 0; pend = 0;
        exp_bus = '0; exp_done = 0; exp_err = 0; exp_ready = 1; exp_busy = 0;
      end else begin
        exp_done = 0;
        exp_err  = 0;
        if (pend) begin
          pend = 0;
          if (pend_ok) begin exp_bus = pend_img; exp_done = 1; end
          else exp_err = 1;
          exp_ready = 1;
        end else if (cfg_valid && exp_ready) begin
          if (!in_frame) begin
            if (cfg_data == 8'hA5) begin
              in_frame = 1; fb.delete(); exp_busy = 1;
            end
          end else begin
            fb.push_back(cfg_data);
            if (fb.size() == N + 1) begin
              logic [7:0] x;
              x = 8'h00; pend_ok = 1; pend_img = '0;
              for (int k = 0; k < N; k++) begin
                pend_ok = pend_ok & legal(fb[k]);
                x = x ^ fb[k];
                pend_img[k*CW +: CW] = fb[k][5:0];
              end
              pend_ok  = pend_ok & (x == fb[N]);
              pend     = 1;
              in_frame = 0;
              exp_busy = 0;
              exp_ready = 0;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  time done_times[$];
  initial begin
    forever begin
      @(negedge clk);
      check("bus",       cfg_bus,   exp_bus);
      check("done",      BW'(cfg_done),  BW'(exp_done));
      check("err",       BW'(cfg_err),   BW'(exp_err));
      check("ready",     BW'(cfg_ready), BW'(exp_ready));
      check("busy",      BW'(busy),      BW'(exp_busy));
      check("done_and_err", BW'(cfg_done & cfg_err), '0);
      if (cfg_done) done_times.push_back($time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required finish");
    $fatal(1);
  end

  // Stimulus helpers.
  logic [7:0]    pl [N];
  logic [7:0]    plb[N];
  logic [7:0]    chkb;
  time           last_xfer_t;

  task automatic send_byte(input logic [7:0] b);
    int tries;
    tries = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = b;
    while (!cfg_ready) begin
      tries++;
      if (tries > 8) begin
        n_cmp++; n_bad++;
        $display("FAIL ready_timeout: ready 0 required 1");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    last_xfer_t = $time;
    #1 cfg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] xor_pl();
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < N; k++) x = x ^ pl[k];
    return x;
  endfunction

  function automatic logic [BW-1:0] img_pl();
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*CW +: CW] = pl[k][5:0];
    return v;
  endfunction

  task automatic rand_pl();
    int side, idx;
    for (int k = 0; k < N; k++) begin
      side = $urandom_range(0, 4);
      if (side == 0)                    idx = $urandom_range(0, 7);
      else if (side == 1 || side == 3)  idx = $urandom_range(0, 4);
      else                              idx = $urandom_range(0, 3);
      pl[k] = {2'b00, 3'(idx), 3'(side)};
    end
  endtask

  task automatic send_frame(input bit gaps);
    send_byte(8'hA5);
    for (int k = 0; k < N; k++) begin
      if (gaps) idle($urandom_range(0, 2));
      send_byte(pl[k]);
    end
    if (gaps) idle($urandom_range(0, 2));
    send_byte(chkb);
  endtask

  task automatic wait_result(output bit d, output bit e, output time t);
    d = 0; e = 0; t = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cfg_done || cfg_err) begin
        d = cfg_done; e = cfg_err; t = $time;
        break;
      end
    end
    if (!d && !e) begin
      n_cmp++; n_bad++;
      $display("FAIL result_timeout: no done/err pulse, required one");
    end
    #1;
  endtask

  logic [7:0]    codes[3];
  logic [BW-1:0] img;
  bit            d, e;
  time           t;
  int            nd;

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_data = 8'h00;
    idle(2);
    check("rst_bus",   cfg_bus, '0);
    check("rst_ready", BW'(cfg_ready), BW'(1));
    rst = 1'b0;
    idle(2);

    // 1: single entry 0x0A, good checksum.
    for (int k = 0; k < N; k++) pl[k] = 8'h00;
    pl[0] = 8'h0A; chkb = 8'h0A;
    send_frame(0);
    wait_result(d, e, t);
    check("t1_done",    BW'(d), BW'(1));
    check("t1_latency", BW'(t - last_xfer_t), BW'(15));
    check("t1_bus",     cfg_bus, BW'(6'h0A));

    // 2: bad checksum.
    chkb = 8'h0B;
    send_frame(0);
    wait_result(d, e, t);
    check("t2_err",  BW'(e), BW'(1));
    check("t2_done", BW'(d), BW'(0));
    check("t2_bus",  cfg_bus, BW'(6'h0A));

    // 3: illegal codes with correct checksum.
    codes[0] = 8'h22; codes[1] = 8'h05; codes[2] = 8'h40;
    for (int i = 0; i < 3; i++) begin
      pl[0] = codes[i]; chkb = codes[i];
      send_frame(0);
      wait_result(d, e, t);
      check($sformatf("t3_err_%02h", codes[i]), BW'(e), BW'(1));
      check($sformatf("t3_bus_%02h", codes[i]), cfg_bus, BW'(6'h0A));
    end

    // 4: junk before header, random valid frame with valid gaps.
    send_byte(8'h00);
    send_byte(8'h5A);
    idle(2);
    rand_pl(); chkb = xor_pl(); img = img_pl();
    send_frame(1);
    wait_result(d, e, t);
    check("t4_done", BW'(d), BW'(1));
    check("t4_bus",  cfg_bus, img);

    // 5: reset after 10 payload bytes, then a good frame.
    send_byte(8'hA5);
    for (int k = 0; k < 10; k++) send_byte(8'h01);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("t5_rst_bus",  cfg_bus, '0);
    check("t5_rst_busy", BW'(busy), BW'(0));
    rst = 1'b0;
    nd = done_times.size();
    rand_pl(); chkb = xor_pl(); img = img_pl();
    send_frame(0);
    wait_result(d, e, t);
    idle(3);
    check("t5_done",  BW'(d), BW'(1));
    check("t5_ndone", BW'(done_times.size() - nd), BW'(1));
    check("t5_bus",   cfg_bus, img);

    // 6: two good frames back-to-back.
    nd = done_times.size();
    rand_pl();
    for (int k = 0; k < N; k++) plb[k] = pl[k];
    rand_pl(); chkb = xor_pl();
    send_frame(0);
    for (int k = 0; k < N; k++) pl[k] = plb[k];
    chkb = xor_pl(); img = img_pl();
    send_frame(0);
    wait_result(d, e, t);
    check("t6_ndone", BW'(done_times.size() - nd), BW'(2));
    if (done_times.size() - nd == 2)
      check("t6_period", BW'(done_times[nd+1] - done_times[nd]), BW'((N + 3) * 10));
    check("t6_bus", cfg_bus, img);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
